sequenciador_rpn: RTL

// - Top-level step controller for the 8-bit RPN ALU: walks the user through operand A, operand B,

---
 rtl/rpn_pkg.sv | 24 ++
 rtl/detector_borda.sv | 24 ++
 rtl/sequenciador_rpn.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN ALU step controller.
// Contents:
//   - DATA_W_DEF / OP_W_DEF : default operand and opcode widths
//   - etapa_t               : step encoding, also driven directly on the Etapa output
//   - OP_*                  : opcode constants understood by the ALU
package rpn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [1:0] {
    ETAPA_A    = 2'b00,
    ETAPA_B    = 2'b01,
    ETAPA_OP   = 2'b10,
    ETAPA_EXEC = 2'b11
  } etapa_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for the debounced confirm button.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset (clears the edge history)
//   nivel  in  button level, active high
//   pulso  out one-cycle pulse in the cycle nivel first reads high
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic nivel,
  output logic pulso
);

  logic nivel_q;

  always_ff @(posedge clk) begin
    if (reset) nivel_q <= 1'b0;
    else       nivel_q <= nivel;
  end

  // Combinational so a press is acted on in the same cycle it arrives.
  assign pulso = nivel & ~nivel_q;

endmodule

// File: rtl/sequenciador_rpn.sv
// Step controller for the 8-bit RPN ALU: operand A, operand B, opcode, execute,
// all driven by one confirm button. A finished result is chained into the next
// operand A unless the user has never completed an operation since reset.
// Ports:
//   CLOCK, Reset_borda        clock and synchronous active-high reset
//   Confirmar                 debounced confirm button level
//   Chaves, Operacao          switch operand and opcode
//   AluResultado, AluDone     ALU result and completion (pulse or level)
//   Etapa                     current step (also the FSM state register)
//   AluStart, LoadResultado   registered one-cycle strobes
//   MuxSelA                   1 = A from switches, 0 = A from last result
//   RegA, RegB, OpReg         latched operands/opcode
//   Resultado, Erro           last captured result, sticky timeout flag
// Handshake: AluStart is high for the first EXECUTA cycle only; AluDone is
// sampled in every EXECUTA cycle, including the AluStart cycle, and is ignored
// in every other step.
module sequenciador_rpn
  import rpn_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int OP_W         = OP_W_DEF,
  parameter int EXEC_TIMEOUT = 255
) (
  input  logic              CLOCK,
  input  logic              Reset_borda,
  input  logic              Confirmar,
  input  logic [DATA_W-1:0] Chaves,
  input  logic [OP_W-1:0]   Operacao,
  input  logic [DATA_W-1:0] AluResultado,
  input  logic              AluDone,
  output logic [1:0]        Etapa,
  output logic              AluStart,
  output logic              LoadResultado,
  output logic              MuxSelA,
  output logic [DATA_W-1:0] RegA,
  output logic [DATA_W-1:0] RegB,
  output logic [OP_W-1:0]   OpReg,
  output logic [DATA_W-1:0] Resultado,
  output logic              Erro
);

  localparam int          CNT_W    = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(EXEC_TIMEOUT);
  // Timeout fires on the edge where the counter would reach EXEC_TIMEOUT,
  // so EXECUTA lasts at most EXEC_TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

  etapa_t           state, state_next;
  logic             pulso;
  logic             chain;
  logic [CNT_W-1:0] cnt;
  logic             start_next, load_next;
  logic             cap_a, cap_b, cap_op, done_ok, timeout;

  detector_borda u_borda (
    .clk   (CLOCK),
    .reset (Reset_borda),
    .nivel (Confirmar),
    .pulso (pulso)
  );

  always_ff @(posedge CLOCK) begin
    if (Reset_borda) begin
      state         <= ETAPA_A;
      AluStart      <= 1'b0;
      LoadResultado <= 1'b0;
    end else begin
      state         <= state_next;
      AluStart      <= start_next;
      LoadResultado <= load_next;
    end
  end

  always_comb begin
    state_next = state;
    start_next = 1'b0;
    load_next  = 1'b0;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    done_ok    = 1'b0;
    timeout    = 1'b0;
    case (state)
      ETAPA_A: if (pulso) begin
        cap_a      = 1'b1;
        state_next = ETAPA_B;
      end
      ETAPA_B: if (pulso) begin
        cap_b      = 1'b1;
        state_next = ETAPA_OP;
      end
      ETAPA_OP: if (pulso) begin
        cap_op     = 1'b1;
        start_next = 1'b1;
        state_next = ETAPA_EXEC;
      end
      ETAPA_EXEC: begin
        // Done has priority over a coincident timeout.
        if (AluDone) begin
          done_ok    = 1'b1;
          load_next  = 1'b1;
          state_next = ETAPA_A;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = ETAPA_A;
        end
      end
      default: state_next = ETAPA_A;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (Reset_borda)                            cnt <= '0;
    else if (cap_op)                            cnt <= '0;
    else if (state == ETAPA_EXEC && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge CLOCK) begin
    if (Reset_borda) begin
      RegA      <= '0;
      RegB      <= '0;
      OpReg     <= '0;
      Resultado <= '0;
      chain     <= 1'b0;
      Erro      <= 1'b0;
    end else begin
      if (cap_a)  RegA  <= MuxSelA ? Chaves : Resultado;
      if (cap_b)  RegB  <= Chaves;
      if (cap_op) OpReg <= Operacao;
      if (done_ok) begin
        Resultado <= AluResultado;
        chain     <= 1'b1;
        Erro      <= 1'b0;
      end else if (timeout) begin
        Erro <= 1'b1;
      end
    end
  end

  assign Etapa   = state;
  assign MuxSelA = ~((state == ETAPA_A) & chain);

endmodule
